// File: rtl/pipeline_stage_skid.sv
// Ready/valid pipeline register with a 2-entry skid buffer, registered in_ready and synchronous flush.
// Optional perf counters (stall_cnt, bubble_cnt) are built when PIPE_PERF_EN is defined.
module pipeline_stage_skid #(
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = '0,
  parameter int                CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
`ifdef PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } entry_t;

  localparam entry_t EMPTY = '{valid: 1'b0, data: NOP_VAL};

  entry_t main_q, skid_q;
  logic   in_fire, out_fire;

  // in_ready comes straight from the skid flop, so no ready path runs through this stage
  assign in_ready  = ~skid_q.valid;
  assign out_valid = main_q.valid;
  assign out_data  = main_q.data;
  assign occupancy = {1'b0, main_q.valid} + {1'b0, skid_q.valid};

  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = main_q.valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q <= EMPTY;
      skid_q <= EMPTY;
    end else if (flush) begin
      main_q <= EMPTY;
      skid_q <= EMPTY;
    end else if (!main_q.valid) begin
      if (in_fire) main_q <= '{valid: 1'b1, data: in_data};
    end else if (!skid_q.valid) begin
      if (in_fire && out_fire)  main_q.data <= in_data;
      else if (in_fire)         skid_q      <= '{valid: 1'b1, data: in_data};
      else if (out_fire)        main_q      <= EMPTY;
    end else if (out_fire) begin
      main_q <= skid_q;
      skid_q <= EMPTY;
    end
  end

`ifdef PIPE_PERF_EN
  // Saturating counters; only reset clears them, flush leaves them alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_q.valid && !out_ready && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!main_q.valid && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Scoreboard bench for pipeline_stage_skid: directed vectors, negedge monitor pops expected payloads.
module tb_pipeline_stage_skid;
  localparam int          DATA_W = 16;
  localparam int          CNT_W  = 4;
  localparam logic [15:0] NOP    = 16'hBEEF;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;
  int base;
  logic [DATA_W-1:0] sb[$];

  pipeline_stage_skid #(.DATA_W(DATA_W), .NOP_VAL(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
`ifdef PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor pops first, then the accepted input (if any) is queued; flush squashes held entries
  always @(negedge clk) begin
    if (rst) sb.delete();
    else begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_unexpected: got %0h, expected no output", out_data);
        end else chk("out_order", out_data, sb.pop_front());
      end
      if (!out_valid) chk("nop_when_idle", out_data, NOP);
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(in_data);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_data", out_data, NOP);

    // async reset mid-cycle with a held word
    in_valid = 1'b1; in_data = 16'h0055;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_occ", occupancy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_occ", occupancy, 0);
    chk("async_rst_out_data", out_data, NOP);
    tick();
    rst = 1'b0;

    // back-to-back stream, one cycle of latency
    out_ready = 1'b1;
    base = n_out;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_data = 16'(i);
      tick();
      chk("stream_valid", out_valid, 1);
      chk("stream_data", out_data, i);
      chk("stream_in_ready", in_ready, 1);
      chk("stream_occ", occupancy, 1);
    end
    in_valid = 1'b0;
    tick();
    chk("stream_drained", occupancy, 0);
    chk("stream_count", n_out - base, 8);

    // stall: A,B fill the stage, C waits upstream
    out_ready = 1'b0; base = n_out;
    in_valid = 1'b1; in_data = 16'h000A;
    tick();
    chk("stall_occ1", occupancy, 1);
    chk("stall_rdy1", in_ready, 1);
    in_data = 16'h000B;
    tick();
    chk("stall_occ2", occupancy, 2);
    chk("stall_rdy0", in_ready, 0);
    chk("stall_head", out_data, 16'h000A);
    in_data = 16'h000C;
    tick();
    chk("stall_hold_occ", occupancy, 2);
    chk("stall_hold_data", out_data, 16'h000A);
    out_ready = 1'b1;
    tick();
    chk("unstall_occ", occupancy, 1);
    chk("unstall_data", out_data, 16'h000B);
    chk("unstall_rdy", in_ready, 1);
    tick();
    chk("unstall_c", out_data, 16'h000C);
    in_valid = 1'b0;
    tick();
    chk("stall_drained", occupancy, 0);
    chk("stall_count", n_out - base, 3);

    // flush while full; D offered that cycle must vanish
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h000E;
    tick();
    in_data = 16'h000F;
    tick();
    chk("flushfull_occ2", occupancy, 2);
    base = n_out;
    in_data = 16'h000D; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flushfull_valid", out_valid, 0);
    chk("flushfull_occ", occupancy, 0);
    chk("flushfull_rdy", in_ready, 1);
    chk("flushfull_data", out_data, NOP);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("flushfull_no_out", n_out - base, 0);

    // flush while one held and an input would otherwise be accepted
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0011;
    tick();
    chk("flushone_occ1", occupancy, 1);
    in_data = 16'h0012; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flushone_occ", occupancy, 0);
    base = n_out;
    out_ready = 1'b1;
    repeat (2) tick();
    chk("flushone_no_out", n_out - base, 0);

    // flush with a same-cycle downstream fire: X still consumed
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 16'h0077;
    tick();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1; base = n_out;
    tick();
    flush = 1'b0;
    chk("flushfire_count", n_out - base, 1);
    chk("flushfire_occ", occupancy, 0);
    chk("flushfire_valid", out_valid, 0);

`ifdef PIPE_PERF_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("perf_rst_stall", stall_cnt, 0);
    chk("perf_rst_bubble", bubble_cnt, 0);
    out_ready = 1'b0;
    repeat (3) tick();
    chk("perf_bubble3", bubble_cnt, 3);
    chk("perf_stall0", stall_cnt, 0);
    in_valid = 1'b1; in_data = 16'h0033;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("perf_stall10", stall_cnt, 10);
    repeat (10) tick();
    chk("perf_stall_sat", stall_cnt, 15);
    chk("perf_bubble4", bubble_cnt, 4);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("perf_flush_keep_stall", stall_cnt, 15);
    chk("perf_flush_keep_bubble", bubble_cnt, 4);
    tick();
    chk("perf_bubble5", bubble_cnt, 5);
`endif

    tick();
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
